// File: rtl/param_frame_aligner_if.sv
// Byte-stream side and aligner status side of the frame aligner, grouped as one bus.
interface param_frame_aligner_if #(
    parameter int unsigned FRAME_LEN = 12
);
    localparam int unsigned POS_W = $clog2(FRAME_LEN);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [POS_W-1:0] fr_byte_position;
    logic             frame_detect;
    logic             frame_start;
    logic             hdr_type;
    logic [7:0]       payload_data;
    logic             payload_valid;
    logic [7:0]       lock_loss_cnt;

    modport master (
        output rx_data, rx_valid,
        input  fr_byte_position, frame_detect, frame_start, hdr_type,
        input  payload_data, payload_valid, lock_loss_cnt
    );

    modport slave (
        input  rx_data, rx_valid,
        output fr_byte_position, frame_detect, frame_start, hdr_type,
        output payload_data, payload_valid, lock_loss_cnt
    );
endinterface

// File: rtl/param_frame_aligner.sv
// Byte-stream frame aligner: hunts a two-type 2-byte header, tracks byte position,
// locks after LOCK_FRAMES legal frames and unlocks after UNLOCK_BYTES non-aligned bytes.
module param_frame_aligner #(
    parameter int unsigned FRAME_LEN    = 12,
    parameter int unsigned LOCK_FRAMES  = 3,
    parameter int unsigned UNLOCK_BYTES = 48,
    parameter logic [7:0]  HDR_A_LSB    = 8'hAA,
    parameter logic [7:0]  HDR_A_MSB    = 8'hAF,
    parameter logic [7:0]  HDR_B_LSB    = 8'h55,
    parameter logic [7:0]  HDR_B_MSB    = 8'hBA
) (
    input  logic                  clk,
    input  logic                  reset_n,
    param_frame_aligner_if.slave  bus
);
    localparam int unsigned POS_W  = $clog2(FRAME_LEN);
    localparam int unsigned LEG_W  = 4;
    localparam int unsigned NA_W   = 8;
    localparam int unsigned LOSS_W = 8;

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
    localparam logic [LEG_W-1:0]  LEGAL_MAX = LEG_W'(LOCK_FRAMES);
    localparam logic [NA_W-1:0]   NA_MAX    = NA_W'(UNLOCK_BYTES);
    localparam logic [LOSS_W-1:0] LOSS_MAX  = '1;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        HDR_MSB = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [POS_W-1:0]  pos_q, pos_n;
    logic [LEG_W-1:0]  legal_cnt, legal_n;
    logic [NA_W-1:0]   na_cnt, na_n;
    logic              lsb_type, lsb_type_n;
    logic              hdr_type_q, hdr_type_n;
    logic              frame_start_q, frame_start_n;
    logic [7:0]        payload_data_q, payload_data_n;
    logic              payload_valid_q, payload_valid_n;
    logic              frame_detect_q, frame_detect_n;
    logic [LOSS_W-1:0] loss_q, loss_n;

    logic              is_a_lsb, is_b_lsb, is_lsb, msb_match;
    logic [LEG_W-1:0]  legal_inc;
    logic [NA_W-1:0]   na_inc;
    logic [POS_W-1:0]  pos_inc;
    logic              na_bumped, lock_set, lock_clr;

    assign is_a_lsb  = (bus.rx_data == HDR_A_LSB);
    assign is_b_lsb  = (bus.rx_data == HDR_B_LSB);
    assign is_lsb    = is_a_lsb | is_b_lsb;
    assign msb_match = lsb_type ? (bus.rx_data == HDR_B_MSB) : (bus.rx_data == HDR_A_MSB);
    assign legal_inc = (legal_cnt >= LEGAL_MAX) ? LEGAL_MAX : legal_cnt + LEG_W'(1);
    assign na_inc    = (na_cnt >= NA_MAX) ? NA_MAX : na_cnt + NA_W'(1);
    assign pos_inc   = pos_q + POS_W'(1);

    // Next-state, counters and output values for one accepted byte.
    always_comb begin
        state_n         = state;
        pos_n           = pos_q;
        legal_n         = legal_cnt;
        na_n            = na_cnt;
        lsb_type_n      = lsb_type;
        hdr_type_n      = hdr_type_q;
        frame_start_n   = 1'b0;
        payload_data_n  = payload_data_q;
        payload_valid_n = 1'b0;
        na_bumped       = 1'b0;
        lock_set        = 1'b0;

        if (bus.rx_valid) begin
            case (state)
                HUNT: begin
                    pos_n     = '0;
                    na_n      = na_inc;
                    na_bumped = 1'b1;
                    if (is_lsb) begin
                        lsb_type_n = is_b_lsb;
                        state_n    = HDR_MSB;
                    end else begin
                        legal_n = '0;
                    end
                end
                HDR_MSB: begin
                    if (msb_match) begin
                        pos_n         = POS_ONE;
                        legal_n       = legal_inc;
                        frame_start_n = 1'b1;
                        hdr_type_n    = lsb_type;
                        state_n       = PAYLOAD;
                        lock_set      = (legal_inc == LEGAL_MAX);
                    end else begin
                        pos_n     = '0;
                        legal_n   = '0;
                        na_n      = na_inc;
                        na_bumped = 1'b1;
                        // A header-LSB byte in the MSB slot re-syncs instead of dropping to HUNT.
                        if (is_lsb) begin
                            lsb_type_n = is_b_lsb;
                            state_n    = HDR_MSB;
                        end else begin
                            state_n = HUNT;
                        end
                    end
                end
                PAYLOAD: begin
                    pos_n           = pos_inc;
                    payload_data_n  = bus.rx_data;
                    payload_valid_n = frame_detect_q;
                    if (pos_inc == POS_LAST) begin
                        na_n    = '0;
                        state_n = HUNT;
                    end
                end
                default: begin
                    state_n = HUNT;
                    pos_n   = '0;
                end
            endcase
        end
    end

    // Lock tracking; a simultaneous set beats the clear and suppresses the loss count.
    assign lock_clr = na_bumped && frame_detect_q && (na_cnt != NA_MAX) && (na_n == NA_MAX);

    always_comb begin
        frame_detect_n = frame_detect_q;
        loss_n         = loss_q;
        if (lock_set) begin
            frame_detect_n = 1'b1;
        end else if (lock_clr) begin
            frame_detect_n = 1'b0;
            if (loss_q != LOSS_MAX) begin
                loss_n = loss_q + LOSS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= HUNT;
            pos_q           <= '0;
            legal_cnt       <= '0;
            na_cnt          <= '0;
            lsb_type        <= 1'b0;
            hdr_type_q      <= 1'b0;
            frame_start_q   <= 1'b0;
            payload_data_q  <= '0;
            payload_valid_q <= 1'b0;
            frame_detect_q  <= 1'b0;
            loss_q          <= '0;
        end else begin
            state           <= state_n;
            pos_q           <= pos_n;
            legal_cnt       <= legal_n;
            na_cnt          <= na_n;
            lsb_type        <= lsb_type_n;
            hdr_type_q      <= hdr_type_n;
            frame_start_q   <= frame_start_n;
            payload_data_q  <= payload_data_n;
            payload_valid_q <= payload_valid_n;
            frame_detect_q  <= frame_detect_n;
            loss_q          <= loss_n;
        end
    end

    assign bus.fr_byte_position = pos_q;
    assign bus.frame_detect     = frame_detect_q;
    assign bus.frame_start      = frame_start_q;
    assign bus.hdr_type         = hdr_type_q;
    assign bus.payload_data     = payload_data_q;
    assign bus.payload_valid    = payload_valid_q;
    assign bus.lock_loss_cnt    = loss_q;

endmodule
